rf_write_port_arbiter: RTL and testbench

// - Shares the single register-file write port between N_REQ writeback requesters.
// - Requesters are e.g. ALU, load unit and CSR unit.
// - Round-robin arbitration with a valid/grant handshake.
// - Registers the winning address and data.
// - Drives a one-hot row write-enable through the team's address decoder.
// - Sits between the execute/memory writeback sources and the register file.

---
 rtl/rf_write_port_arbiter_if.sv | 29 ++
 rtl/rf_write_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rf_write_port_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rf_write_port_arbiter_if.sv
// Writeback-request bus between the N_REQ requesters and the register-file
// write-port arbiter, plus the registered write port toward the register file.
interface rf_write_port_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] data;
  logic [N_REQ-1:0]        gnt;
  logic                    rf_wr_ena;
  logic [ADDR_W-1:0]       rf_wr_addr;
  logic [DATA_W-1:0]       rf_wr_data;
  logic [2**ADDR_W-1:0]    rf_wr_onehot;

  // Requester side
  modport master (
    output req, lock, addr, data,
    input  gnt, rf_wr_ena, rf_wr_addr, rf_wr_data, rf_wr_onehot
  );

  // Arbiter side
  modport slave (
    input  req, lock, addr, data,
    output gnt, rf_wr_ena, rf_wr_addr, rf_wr_data, rf_wr_onehot
  );
endinterface

// File: rtl/rf_write_port_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// N_REQ writeback requesters. Winner address/data are registered and decoded
// into a one-hot row enable; writes to x0 are granted but dropped.
// Optional burst locking is enabled by defining ARB_BURST_EN.
module rf_write_port_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_write_port_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [0:0]        state_q, state_d;
  logic              rf_wr_ena_q, rf_wr_ena_d;
  logic [ADDR_W-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;

`ifdef ARB_BURST_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

  logic             arb_found;
  logic [PTR_W-1:0] arb_win;
  logic [PTR_W-1:0] win;
  logic [N_REQ-1:0] gnt_c;
  logic             xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Round-robin search starting one past the last winner, wrapping at N_REQ-1
  always_comb begin
    logic [PTR_W-1:0] cand;
    arb_found = 1'b0;
    arb_win   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = PTR_W'((32'(ptr_q) + off) % N_REQ);
      if (!arb_found && bus.req[cand]) begin
        arb_found = 1'b1;
        arb_win   = cand;
      end
    end
  end

  // Grant selection: locked owner only, otherwise the round-robin winner; none in reset
  always_comb begin
    gnt_c = '0;
    win   = arb_win;
    if (!rst) begin
`ifdef ARB_BURST_EN
      if (state_q == LOCKED) begin
        win           = owner_q;
        gnt_c[owner_q] = bus.req[owner_q];
      end else if (arb_found) begin
        gnt_c[arb_win] = 1'b1;
      end
`else
      if (arb_found) begin
        gnt_c[arb_win] = 1'b1;
      end
`endif
    end
    xfer     = |(gnt_c & bus.req);
    win_addr = bus.addr[32'(win)*ADDR_W +: ADDR_W];
    win_data = bus.data[32'(win)*DATA_W +: DATA_W];
  end

  assign bus.gnt = gnt_c;

  // Next-state for pointer, FSM, burst tracking and the registered write port
  always_comb begin
    ptr_d        = ptr_q;
    state_d      = state_q;
    rf_wr_ena_d  = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
`ifdef ARB_BURST_EN
    owner_d      = owner_q;
    burst_cnt_d  = burst_cnt_q;
`endif

    if (xfer) begin
      ptr_d        = win;
      rf_wr_ena_d  = (win_addr != '0);
      rf_wr_addr_d = win_addr;
      rf_wr_data_d = win_data;
    end

`ifdef ARB_BURST_EN
    // MAX_BURST == 1 never enters LOCKED, matching the unlocked build
    if (state_q == ARB) begin
      if (xfer && bus.lock[win] && (MAX_BURST > 1)) begin
        state_d     = LOCKED;
        owner_d     = win;
        burst_cnt_d = CNT_W'(1);
      end
    end else begin
      if (xfer) begin
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
        if (!bus.lock[owner_q] || (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
          state_d     = ARB;
          burst_cnt_d = '0;
        end
      end else begin
        state_d     = ARB;
        burst_cnt_d = '0;
        ptr_d       = owner_q;
      end
    end
`else
    state_d = ARB;
`endif
  end

  // State registers with synchronous reset; pointer resets so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= PTR_W'(N_REQ - 1);
      state_q      <= ARB;
      rf_wr_ena_q  <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
`ifdef ARB_BURST_EN
      owner_q      <= '0;
      burst_cnt_q  <= '0;
`endif
    end else begin
      ptr_q        <= ptr_d;
      state_q      <= state_d;
      rf_wr_ena_q  <= rf_wr_ena_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
`ifdef ARB_BURST_EN
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
`endif
    end
  end

  // One-hot row enable decoded from the registered address, gated by enable
  always_comb begin
    bus.rf_wr_onehot = '0;
    if (rf_wr_ena_q) begin
      bus.rf_wr_onehot[rf_wr_addr_q] = 1'b1;
    end
  end

  assign bus.rf_wr_ena  = rf_wr_ena_q;
  assign bus.rf_wr_addr = rf_wr_addr_q;
  assign bus.rf_wr_data = rf_wr_data_q;

endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// Directed bench for rf_write_port_arbiter (N_REQ=4, ADDR_W=5, DATA_W=32).
// Expected writes are queued when a grant is expected and popped one cycle later.
module tb_rf_write_port_arbiter;

  typedef struct {
    logic        ena;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0]  req_v;
  logic [3:0]  lock_v;
  logic [4:0]  addr_v [4];
  logic [31:0] data_v [4];

  wr_t         sb [$];
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  rf_write_port_arbiter_if #(.N_REQ(4), .ADDR_W(5), .DATA_W(32)) bus ();

  rf_write_port_arbiter #(
    .N_REQ(4), .ADDR_W(5), .DATA_W(32), .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always_comb begin
    bus.req  = req_v;
    bus.lock = lock_v;
    for (int i = 0; i < 4; i++) begin
      bus.addr[i*5 +: 5]   = addr_v[i];
      bus.data[i*32 +: 32] = data_v[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check gnt mid-cycle, then the registered port just after the edge
  task automatic step(input string tag, input logic [3:0] exp_gnt);
    wr_t         e;
    logic        exp_ena;
    logic [31:0] exp_oh;
    @(negedge clk);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(exp_gnt));
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (exp_gnt[i] && req_v[i]) begin
          e.ena  = (addr_v[i] != 5'd0);
          e.addr = addr_v[i];
          e.data = data_v[i];
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      exp_ena   = 1'b0;
      last_addr = '0;
      last_data = '0;
    end else if (sb.size() > 0) begin
      e         = sb.pop_front();
      exp_ena   = e.ena;
      last_addr = e.addr;
      last_data = e.data;
    end else begin
      exp_ena = 1'b0;
    end
    exp_oh = exp_ena ? (32'd1 << last_addr) : 32'd0;
    chk({tag, ".ena"},    32'(bus.rf_wr_ena),  32'(exp_ena));
    chk({tag, ".addr"},   32'(bus.rf_wr_addr), 32'(last_addr));
    chk({tag, ".data"},   bus.rf_wr_data,      last_data);
    chk({tag, ".onehot"}, bus.rf_wr_onehot,    exp_oh);
  endtask

  initial begin
    rst    = 1'b1;
    req_v  = 4'b1111;
    lock_v = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      addr_v[i] = 5'(i + 1);
      data_v[i] = 32'hA000_0000 + 32'(i);
    end
    last_addr = '0;
    last_data = '0;

    // Reset with all requesters active
    step("rst0", 4'b0000);
    step("rst1", 4'b0000);
    rst = 1'b0;

    // Round robin from requester 0
    step("rr0", 4'b0001);
    step("rr1", 4'b0010);
    step("rr2", 4'b0100);
    step("rr3", 4'b1000);
    step("rr4", 4'b0001);

    // x0 write granted but dropped
    req_v     = 4'b0001;
    addr_v[0] = 5'd0;
    data_v[0] = 32'hDEAD;
    step("x0", 4'b0001);

    // Idle: no grant, outputs hold
    req_v = 4'b0000;
    step("idle", 4'b0000);

    // Decode of address 17
    req_v     = 4'b0100;
    addr_v[2] = 5'd17;
    data_v[2] = 32'hCAFE_F00D;
    step("dec17", 4'b0100);

    // Single continuous requester gets every cycle
    req_v     = 4'b1000;
    addr_v[3] = 5'd31;
    step("cont0", 4'b1000);
    data_v[3] = 32'h1234_5678;
    step("cont1", 4'b1000);
    data_v[3] = 32'h8765_4321;
    step("cont2", 4'b1000);

    // Simultaneous requests resolve by pointer (ptr=3, then 1)
    req_v     = 4'b0110;
    addr_v[1] = 5'd9;
    step("sim0", 4'b0010);
    req_v     = 4'b0101;
    addr_v[0] = 5'd4;
    step("sim1", 4'b0100);

`ifdef ARB_BURST_EN
    // Burst of MAX_BURST from requester 0, then requester 1
    rst    = 1'b1;
    req_v  = 4'b0011;
    lock_v = 4'b0001;
    step("brst_rst", 4'b0000);
    rst = 1'b0;
    step("b0", 4'b0001);
    step("b1", 4'b0001);
    step("b2", 4'b0001);
    step("b3", 4'b0001);
    step("b4", 4'b0010);

    // Reset on the 2nd locked cycle; burst restarts from one
    rst = 1'b1;
    step("mb_rst0", 4'b0000);
    rst = 1'b0;
    step("mb0", 4'b0001);
    rst = 1'b1;
    step("mb_rst1", 4'b0000);
    rst = 1'b0;
    step("mb1", 4'b0001);
    step("mb2", 4'b0001);
    step("mb3", 4'b0001);
    step("mb4", 4'b0001);
    step("mb5", 4'b0010);
`else
    // lock is ignored: requesters 0 and 1 alternate (ptr=2)
    req_v  = 4'b0011;
    lock_v = 4'b0001;
    step("nolock0", 4'b0001);
    step("nolock1", 4'b0010);
    step("nolock2", 4'b0001);
`endif

    req_v  = 4'b0000;
    lock_v = 4'b0000;
    step("drain", 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
